uart_frame_serializer: RTL
==========================

// Module: uart_frame_serializer
// PURPOSE
//  Parametrised game-state framer feeding the 16-bit UART word path in the game top level.
//  Generalises the fixed position/score multiplexer to N_FIELDS words of FIELD_W bits.
//  Snapshots all fields atomically and emits a framed packet: SYNC, fields 0..N-1, optional checksum.
//  Frames start on request or on an internal periodic timer. Output is a valid/ready word stream
//  to the 16-to-8 converter.
// PARAMETERS
//  N_FIELDS     8        number of payload words per frame (1..64)
//  FIELD_W      16       width of every word, incl. sync and checksum
//  SYNC_WORD    16'hA5A5 first word of each frame (FIELD_W bits)
//  CSUM_EN      1        1: append checksum word; 0: frame ends after last field
//  AUTO_PERIOD  0        0: request-driven; >0: self-start every AUTO_PERIOD cycles
// PORTS
//  clk          in   1                  system clock (65 MHz domain)
//  rst          in   1                  asynchronous, active-high reset
//  fields_flat  in   N_FIELDS*FIELD_W   field k = fields_flat[k*FIELD_W +: FIELD_W]
//  frame_req    in   1                  single-cycle start request (ignored when AUTO_PERIOD>0)
//  clr_ovr      in   1                  clears sticky overrun flag
//  word_out     out  FIELD_W            current word
//  word_valid   out  1                  word_out valid
//  word_ready   in   1                  sink accepts word (conv16to8ready)
//  busy         out  1                  frame in progress (state != IDLE)
//  frame_done   out  1                  one-cycle pulse after last word accepted
//  frame_cnt    out  16                 frames completed, wraps 16'hFFFF->0
//  overrun      out  1                  sticky: start request lost
// BEHAVIOUR
//  - Reset: state IDLE; word_out=0; word_valid/busy/frame_done/overrun=0; frame_cnt=0; pending=0;
//    timer=0. Reset mid-frame aborts with no partial flush; the next frame restarts at SYNC.
//  - Start condition: frame_req=1, or timer reaching AUTO_PERIOD-1 (timer then wraps to 0 and runs
//    continuously from reset).
//  - IDLE + start at edge t: latch fields_flat into snapshot, clear csum accumulator, go SYNC;
//    word_valid=1 and word_out=SYNC_WORD in cycle t+1.
//  - Transfer = word_valid & word_ready at a clock edge. word_out is held stable while valid & !ready.
//    word_valid never drops mid-frame.
//  - SYNC -> FIELD(idx=0) on transfer. FIELD: word_out=snap[idx]; on transfer acc+=snap[idx]
//    mod 2^FIELD_W. idx increments; after idx=N_FIELDS-1 go CSUM (CSUM_EN=1) or DONE.
//  - CSUM: word_out = -(sum of fields) mod 2^FIELD_W, so fields+csum == 0; sync is excluded.
//    Go DONE on transfer.
//  - DONE (1 cycle): word_valid=0, frame_done=1, frame_cnt++. Then pending ? start immediately
//    (new snapshot, SYNC next cycle) : IDLE.
//  - Start while busy (incl. DONE): pending<=1. Start while pending already 1: overrun<=1
//    (request dropped).
//  - Start in the same cycle as the DONE->start transition is absorbed as the new pending.
//  - clr_ovr clears overrun; simultaneous set and clr -> set wins.
//  - Snapshot is immune to fields_flat changes during the frame.
//  - Frame length = 1+N_FIELDS+CSUM_EN words. Minimum frame period with word_ready tied high
//    = length+1 cycles.
// TESTING
//  - N=3, CSUM_EN=1, fields {3,2,1}, ready=1, frame_req pulse -> words A5A5,0001,0002,0003,FFFA on
//    consecutive cycles; frame_done pulse once; frame_cnt=1.
//  - Ready toggles 1/0 randomly; fields_flat changed mid-frame -> words identical to snapshot and
//    stable while stalled; no dropped or duplicated words.
//  - Two reqs during frame -> 2nd sets pending (back-to-back frame, 1 idle cycle); 3rd sets overrun;
//    clr_ovr with new req same cycle -> overrun stays 1.
//  - AUTO_PERIOD=20, N=2, CSUM_EN=0, ready=1 -> SYNC issued every 20 cycles; frame_req ignored.
//  - rst asserted while in FIELD idx=1 -> outputs 0 asynchronously; next req emits from SYNC.
//  - frame_cnt preset via 65535 frames (or force) -> wraps to 0 on next frame_done.

Source files
------------

// File: rtl/uart_frame_serializer.sv
// Game-state framer: snapshots N_FIELDS words and streams SYNC, fields and an optional
// two's-complement checksum as a valid/ready word stream toward the 16-to-8 converter.
module uart_frame_serializer #(
    parameter int                 N_FIELDS    = 8,
    parameter int                 FIELD_W     = 16,
    parameter logic [FIELD_W-1:0] SYNC_WORD   = 16'hA5A5,
    parameter bit                 CSUM_EN     = 1'b1,
    parameter int                 AUTO_PERIOD = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_FIELDS*FIELD_W-1:0] fields_flat,
    input  logic                        frame_req,
    input  logic                        clr_ovr,
    output logic [FIELD_W-1:0]          word_out,
    output logic                        word_valid,
    input  logic                        word_ready,
    output logic                        busy,
    output logic                        frame_done,
    output logic [15:0]                 frame_cnt,
    output logic                        overrun
);

    localparam int IDX_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int TMR_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FIELDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_FIELD,
        ST_CSUM,
        ST_DONE
    } state_t;

    // Handshake: a word moves when word_valid & word_ready at a rising edge; while valid is
    // high and ready is low, word_out holds, and valid stays high until the frame's last word.
    state_t             state;
    logic [FIELD_W-1:0] snap [N_FIELDS];
    logic [IDX_W-1:0]   idx;
    logic [FIELD_W-1:0] acc;
    logic               pending;

    logic               timer_hit;
    logic               start;
    logic               transfer;
    logic               launch;
    logic               in_frame;
    logic [FIELD_W-1:0] cur_field;
    logic [FIELD_W-1:0] next_field;
    logic [FIELD_W-1:0] acc_sum;
    logic [FIELD_W-1:0] csum_word;

    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);
            logic [TMR_W-1:0] timer;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    timer <= '0;
                end else if (timer == TMR_LAST) begin
                    timer <= '0;
                end else begin
                    timer <= timer + 1'b1;
                end
            end

            assign timer_hit = (timer == TMR_LAST);
        end else begin : g_manual
            assign timer_hit = 1'b0;
        end
    endgenerate

    // The request pin is only honoured in request-driven mode.
    assign start      = timer_hit | ((AUTO_PERIOD == 0) ? frame_req : 1'b0);
    assign transfer   = word_valid & word_ready;
    assign launch     = ((state == ST_IDLE) && (start || pending)) ||
                        ((state == ST_DONE) && pending);
    assign in_frame   = (state == ST_SYNC) || (state == ST_FIELD) || (state == ST_CSUM);
    assign cur_field  = snap[idx];
    assign next_field = (idx == LAST_IDX) ? snap[0] : snap[idx + 1'b1];
    assign acc_sum    = acc + cur_field;
    assign csum_word  = '0 - acc_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_FIELDS; k++) begin
                snap[k] <= '0;
            end
        end else if (launch) begin
            for (int k = 0; k < N_FIELDS; k++) begin
                snap[k] <= fields_flat[k*FIELD_W +: FIELD_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            acc        <= '0;
            pending    <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // A lost request outranks a simultaneous clear.
            overrun    <= (start && pending && in_frame) | (overrun & ~clr_ovr);

            case (state)
                ST_IDLE: begin
                    pending <= pending & start;
                    if (launch) begin
                        state      <= ST_SYNC;
                        acc        <= '0;
                        word_out   <= SYNC_WORD;
                        word_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                ST_SYNC: begin
                    if (start) pending <= 1'b1;
                    if (transfer) begin
                        state    <= ST_FIELD;
                        idx      <= '0;
                        word_out <= snap[0];
                    end
                end

                ST_FIELD: begin
                    if (start) pending <= 1'b1;
                    if (transfer) begin
                        acc <= acc_sum;
                        if (idx != LAST_IDX) begin
                            idx      <= idx + 1'b1;
                            word_out <= next_field;
                        end else if (CSUM_EN) begin
                            state    <= ST_CSUM;
                            word_out <= csum_word;
                        end else begin
                            state      <= ST_DONE;
                            word_out   <= '0;
                            word_valid <= 1'b0;
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end
                    end
                end

                ST_CSUM: begin
                    if (start) pending <= 1'b1;
                    if (transfer) begin
                        state      <= ST_DONE;
                        word_out   <= '0;
                        word_valid <= 1'b0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                    end
                end

                ST_DONE: begin
                    // A start arriving now becomes the pending request for after this launch.
                    pending <= start;
                    if (pending) begin
                        state      <= ST_SYNC;
                        acc        <= '0;
                        word_out   <= SYNC_WORD;
                        word_valid <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    word_out   <= '0;
                    word_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
